// File: rtl/sincos_arbiter.sv
// sincos_arbiter: round-robin sharing of one fixed-latency sin/cos unit between two lanes,
// with per-lane credits so the response FIFOs can never overflow and the unit never stalls.
module sincos_arbiter #(
  parameter int LAT = 1,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [15:0] req0_u,
  input  logic [15:0] req1_u,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        sc_vld,
  output logic [15:0] sc_u,
  input  logic [15:0] sc_g0,
  input  logic [15:0] sc_g1,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] rsp0_g0,
  output logic [15:0] rsp0_g1,
  output logic [15:0] rsp1_g0,
  output logic [15:0] rsp1_g1,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic        busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  logic [CW-1:0] cred [2];
  logic [CW-1:0] cnt [2];
  logic [CW-1:0] cnt_n [2];
  logic [AW-1:0] wp [2];
  logic [AW-1:0] rp [2];
  logic [31:0] mem [2][DEPTH];
  logic [LAT:0] pv, pl;
  logic [1:0] ok, acc, pop, wr;
  logic prio, busy_n;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign ok = {cred[1] != '0, cred[0] != '0};
  assign req0_ready = ok[0] & (!req1_valid | !ok[1] | !prio);
  assign req1_ready = ok[1] & (!req0_valid | !ok[0] | prio);
  assign acc = {req1_valid & req1_ready, req0_valid & req0_ready};
  // pv/pl bit 0 is the sc_vld stage; bit LAT lines up with sc_g0/sc_g1
  assign wr = {2{pv[LAT]}} & {pl[LAT], !pl[LAT]};
  assign pop = {rsp1_valid & rsp1_ready, rsp0_valid & rsp0_ready};
  assign sc_vld = pv[0];
  assign rsp0_valid = cnt[0] != '0;
  assign rsp1_valid = cnt[1] != '0;
  assign {rsp0_g0, rsp0_g1} = rsp0_valid ? mem[0][rp[0]] : '0;
  assign {rsp1_g0, rsp1_g1} = rsp1_valid ? mem[1][rp[1]] : '0;
  assign cnt_n[0] = cnt[0] + CW'(wr[0]) - CW'(pop[0]);
  assign cnt_n[1] = cnt[1] + CW'(wr[1]) - CW'(pop[1]);
  assign busy_n = (|pv[LAT-1:0]) | (|acc) | cnt_n[0] != '0 | cnt_n[1] != '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prio <= 1'b0;
      sc_u <= '0;
      pv <= '0;
      pl <= '0;
      busy <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        cred[i] <= CW'(DEPTH);
        cnt[i] <= '0;
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      if (|acc) begin
        prio <= acc[0];
        sc_u <= acc[1] ? req1_u : req0_u;
      end
      pv <= {pv[LAT-1:0], |acc};
      pl <= {pl[LAT-1:0], acc[1]};
      busy <= busy_n;
      for (int i = 0; i < 2; i++) begin
        cred[i] <= cred[i] - CW'(acc[i]) + CW'(pop[i]);
        cnt[i] <= cnt_n[i];
        if (wr[i]) wp[i] <= inc(wp[i]);
        if (pop[i]) rp[i] <= inc(rp[i]);
      end
    end
  always_ff @(posedge clk)
    for (int i = 0; i < 2; i++) if (wr[i]) mem[i][wp[i]] <= {sc_g0, sc_g1};
  assert property (@(posedge clk) disable iff (!rst) wr[0] |-> cnt[0] != CW'(DEPTH));
  assert property (@(posedge clk) disable iff (!rst) wr[1] |-> cnt[1] != CW'(DEPTH));
endmodule

// File: doc/sincos_arbiter.md
# sincos_arbiter

Shares one pipelined sine/cosine evaluation unit between two Box-Muller noise lanes. Each lane presents 16-bit uniform samples U1 over a valid/ready handshake. The arbiter issues them round-robin to the shared unit and tracks each in-flight sample with a tag pipeline. It then steers the returned (g0 = sin 2πU1, g1 = cos 2πU1) pair into that lane's response FIFO. Credit-based admission guarantees a response FIFO can never overflow, so the shared unit never needs to stall.

## Interface
- LAT, default 1: fixed latency of the shared unit, in clock edges from sc_vld/sc_u being presented to sc_g0/sc_g1 being valid. Range 1..8.
- DEPTH, default 4: response FIFO depth per lane, which is also the credit count per lane. Range 2..16.
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  lane N offers a sample.
- req0_u / req1_u  in  16  uniform sample U1 for lane N.
- req0_ready / req1_ready  out  1  lane N sample accepted this cycle if its valid is also high.
- sc_vld  out  1  registered strobe to the shared unit.
- sc_u  out  16  registered sample to the shared unit.
- sc_g0, sc_g1  in  16 each  unit results, valid exactly LAT edges after the matching sc_vld.
- rsp0_valid / rsp1_valid  out  1  lane N FIFO is non-empty.
- rsp0_g0, rsp0_g1 / rsp1_g0, rsp1_g1  out  16 each  head entry of lane N's FIFO (show-ahead).
- rsp0_ready / rsp1_ready  in  1  lane N pops its head entry when valid and ready are both high.
- busy  out  1  high while any tag is in flight or any FIFO is non-empty.

## Operation
- **Credits.** Each lane has a counter cred_N, width $clog2(DEPTH+1), reset to DEPTH.
  - Decrement on accept (reqN_valid & reqN_ready).
  - Increment on pop (rspN_valid & rspN_ready).
  - If both happen in one cycle, the counter is unchanged.
- **Eligibility.** Lane N is eligible when cred_N != 0.
- **Round-robin pointer.** prio, 1 bit, names the preferred lane. Reset value is 0, so lane 0 wins first.
- **Ready equations.** Combinational, and never dependent on the lane's own valid:
  - req0_ready = (cred0 != 0) & (!req1_valid | cred1 == 0 | prio == 0)
  - req1_ready = (cred1 != 0) & (!req0_valid | cred0 == 0 | prio == 1)
- **Pointer update.** At most one accept per cycle. On an accept from lane N, prio becomes !N. With no accept, prio holds.
- **Issue.** On accept, the next edge loads sc_u = reqN_u and sc_vld = 1. With no accept, sc_vld = 0 and sc_u holds its value.
- **Tag pipeline.** A LAT-stage shift register of {valid, lane id} entries, loaded in parallel with sc_vld. Its output stage lines up with sc_g0/sc_g1.
- **Capture.** When the tag output is valid, {sc_g0, sc_g1} is written into the FIFO named by the tag's lane id on the next edge. This is 32 bits per entry.
- **FIFOs.** Each is DEPTH entries deep, with pointers that wrap modulo DEPTH. Simultaneous write and pop is legal in every state, including empty (the new entry becomes visible the next cycle) and full minus one.
- **No overflow.** Credits bound in-flight plus stored entries per lane to DEPTH, so a write can never hit a full FIFO. An assertion checks this.
- **Order.** Response order within a lane equals its accept order. There is no ordering relation between lanes.

## Timing
- **Reset values.** All outputs are 0: sc_vld, sc_u, rsp*_valid, rsp*_g0/g1, busy.
  - req*_ready goes to 1 as soon as rst is released, because credits reset to DEPTH.
- **Latency.** An accept at edge E0 gives sc_vld high after E0, and the result is valid on sc_g after E0+LAT. rspN_valid rises after edge E0+LAT+1, i.e. LAT+1 edges. With LAT=1 that is 2 edges.
- **Throughput.** One accept per cycle in aggregate. Both lanes continuously valid with credit alternate 0,1,0,1…
- **Credit exhaustion.** A lane with DEPTH results outstanding (unpopped or in flight) has ready = 0, and the other lane gets every slot.
- **Reset mid-operation.** Asserting rst clears the tag pipeline, both FIFOs, credits (back to DEPTH) and prio immediately. In-flight results returning after release are discarded because their tags are gone.
- **busy** is registered and reflects state after each edge.

## Test plan
- **Reset.** LAT=1, DEPTH=4, assert rst, drive sc_g0 = 16'h1234 -> all outputs 0. After release, req0_ready = req1_ready = 1 and rsp0_valid stays 0.
- **Single sample.** req0 sends U=16'h4000, accepted at E0 -> sc_u=16'h4000 and sc_vld=1 after E0. The model returns g0=16'h7FFF, g1=16'h0000 after E0+1. rsp0_valid=1 with those values after E0+2. Lane 1 stays silent.
- **Contention.** Both lanes valid for 8 cycles, all rsp_ready=1 -> grants alternate 0,1,0,1 starting with lane 0. Each lane gets 4 responses, in order, tagged correctly.
- **Backpressure.** rsp0_ready=0, req0 always valid -> exactly 4 accepts, then req0_ready=0 while lane 1 continues at full rate. Pulse rsp0_ready for 1 cycle -> exactly one further lane-0 accept.
- **Simultaneous pop, issue and write.** Lane 0 FIFO holds 2 entries; pop, accept and capture all occur on one edge -> credit unchanged, count unchanged, head advances correctly.
- **Mid-flight reset.** Pulse rst low while 3 tags are in flight -> no rsp_valid after release, credits read back as 4, and the first post-reset grant goes to lane 0.
